midi_cc_engine: RTL and testbench

Parametrised MIDI Control Change engine for N debounced buttons. It serialises CC messages on a 31250-baud UART transmitter driven by a single-clock tick, with no derived clocks. It also parses incoming MIDI so that host CC feedback drives per-button LEDs. Per-button toggle mode and optional running status are supported. It replaces the fixed 4-button, send-only controller in the top level; the debounce instances stay outside.

---
 rtl/midi_cc_engine_if.sv | 32 +++
 rtl/midi_cc_engine.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_midi_cc_engine.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_cc_engine_if.sv
// Signal bundle between the MIDI CC engine and its surroundings:
// button press pulses, serial in/out, LEDs and status flags.
interface midi_cc_engine_if #(
    parameter int NUM_BTNS = 4
);
    logic [NUM_BTNS-1:0] btn_rise;
    logic                midi_rx;
    logic                midi_tx;
    logic [NUM_BTNS-1:0] btn_led;
    logic                tx_busy;
    logic                rx_err;

    // Driver side: produces presses and serial input, observes the engine
    modport master (
        output btn_rise,
        output midi_rx,
        input  midi_tx,
        input  btn_led,
        input  tx_busy,
        input  rx_err
    );

    // Engine side
    modport slave (
        input  btn_rise,
        input  midi_rx,
        output midi_tx,
        output btn_led,
        output tx_busy,
        output rx_err
    );
endinterface

// File: rtl/midi_cc_engine.sv
// MIDI Control Change engine: queues button presses, serialises CC messages
// on a single-clock UART transmitter, and parses incoming MIDI so host CC
// feedback drives the per-button LEDs (and toggle state).
module midi_cc_engine #(
    parameter int                  CLK_HZ         = 100000000,
    parameter int                  BAUD           = 31250,
    parameter int                  NUM_BTNS       = 4,
    parameter int                  FIRST_CC       = 46,
    parameter int                  CHANNEL        = 0,
    parameter logic [NUM_BTNS-1:0] TOGGLE_MASK    = '0,
    parameter bit                  RUNNING_STATUS = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    midi_cc_engine_if.slave bus
);
    localparam int BIT_CNT  = CLK_HZ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CW       = $clog2(BIT_CNT + 1);
    localparam int IW       = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;

    localparam logic [7:0]    CC_STATUS = 8'hB0 | 8'(CHANNEL);
    localparam logic [7:0]    CC_LO     = 8'(FIRST_CC);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] BIT_PRE   = CW'(BIT_CNT - 2);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Press queue and arbitration
    logic [NUM_BTNS-1:0] pending;
    logic [NUM_BTNS-1:0] deq_mask;
    logic [IW-1:0]       deq_idx;
    logic                deq_vld;
    logic                load_q;
    logic [IW-1:0]       sel_q;
    logic [7:0]          val_q;

    // Transmitter
    logic                tx_busy;
    logic                tx_line;
    logic [CW-1:0]       baud;
    logic [4:0]          bit_idx;
    logic [4:0]          bits_last;
    logic                last_sent;
    logic [28:0]         tx_sh;
    logic [29:0]         frame;
    logic [7:0]          cc_num;
    logic                short_msg;
    logic                tx_free;

    // Receiver and parser
    logic                rx_s1, rx_s2, rx_prev;
    rx_state_t           rx_state;
    logic [CW-1:0]       rx_cnt;
    logic [2:0]          rx_bitn;
    logic [7:0]          rx_sh;
    logic                byte_vld;
    logic                rx_err_q;
    logic [7:0]          status;
    logic                data_idx;
    logic [7:0]          d1;
    logic                fb_vld;
    logic [7:0]          fb_d1;
    logic                fb_val;
    logic [NUM_BTNS-1:0] fb_mask;

    // Button state
    logic [NUM_BTNS-1:0] tog;
    logic [NUM_BTNS-1:0] led;

    // Next message may be dequeued one cycle before the current one ends so
    // the following frame loads exactly when the last stop bit finishes.
    assign tx_free = (!tx_busy ||
                      (baud == BIT_PRE && bit_idx == bits_last)) && !load_q;

    // Lowest-index pending button wins when the transmitter can accept work
    always_comb begin
        deq_vld  = 1'b0;
        deq_idx  = '0;
        deq_mask = '0;
        if (tx_free) begin
            for (int i = NUM_BTNS - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    deq_vld  = 1'b1;
                    deq_idx  = IW'(i);
                    deq_mask = '0;
                    deq_mask[i] = 1'b1;
                end
            end
        end
    end

    // Pending set/clear; a rise in the dequeue cycle keeps the bit set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            load_q  <= 1'b0;
        end else begin
            pending <= (pending & ~deq_mask) | bus.btn_rise;
            load_q  <= deq_vld;
        end
    end

    // Capture the dequeued button and its data2 value (toggle value is the
    // flipped state, fixed at dequeue so later RX feedback cannot alter it)
    always_ff @(posedge clk) begin
        if (deq_vld) begin
            sel_q <= deq_idx;
            if (|(deq_mask & TOGGLE_MASK) && |(deq_mask & tog))
                val_q <= 8'h00;
            else
                val_q <= 8'h7F;
        end
    end

    // Frame image, transmitted LSB first: start, 8 data bits, stop per byte
    always_comb begin
        cc_num    = CC_LO + 8'(sel_q);
        short_msg = RUNNING_STATUS && last_sent;
        frame     = {1'b1, val_q, 1'b0, 1'b1, cc_num, 1'b0, 1'b1, CC_STATUS, 1'b0};
        if (short_msg)
            frame = {10'h3FF, 1'b1, val_q, 1'b0, 1'b1, cc_num, 1'b0};
    end

    // Transmitter control: bit timing, line level and busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_busy   <= 1'b0;
            tx_line   <= 1'b1;
            baud      <= '0;
            bit_idx   <= '0;
            bits_last <= 5'd29;
            last_sent <= 1'b0;
        end else if (load_q) begin
            tx_busy   <= 1'b1;
            tx_line   <= frame[0];
            baud      <= '0;
            bit_idx   <= '0;
            bits_last <= short_msg ? 5'd19 : 5'd29;
            last_sent <= 1'b1;
        end else if (tx_busy) begin
            if (baud == BIT_LAST) begin
                baud <= '0;
                if (bit_idx == bits_last) begin
                    tx_busy <= 1'b0;
                    tx_line <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 5'd1;
                    tx_line <= tx_sh[0];
                end
            end else begin
                baud <= baud + 1'b1;
            end
        end
    end

    // Remaining frame bits, shifted out at each bit boundary
    always_ff @(posedge clk) begin
        if (load_q)
            tx_sh <= frame[29:1];
        else if (tx_busy && baud == BIT_LAST)
            tx_sh <= {1'b1, tx_sh[28:1]};
    end

    // Two-flop synchroniser plus previous sample for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.midi_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver FSM: half-bit start qualification, then mid-bit sampling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bitn  <= '0;
            rx_sh    <= '0;
            byte_vld <= 1'b0;
            rx_err_q <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            rx_err_q <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bitn  <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        if (rx_bitn == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_bitn <= rx_bitn + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2)
                            byte_vld <= 1'b1;
                        else
                            rx_err_q <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // MIDI parser: realtime bytes pass through untouched, running status kept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status   <= 8'h00;
            data_idx <= 1'b0;
            d1       <= '0;
            fb_vld   <= 1'b0;
            fb_d1    <= '0;
            fb_val   <= 1'b0;
        end else begin
            fb_vld <= 1'b0;
            if (byte_vld && rx_sh < 8'hF8) begin
                if (rx_sh[7]) begin
                    status   <= rx_sh;
                    data_idx <= 1'b0;
                end else if (status == CC_STATUS) begin
                    if (!data_idx) begin
                        d1       <= rx_sh;
                        data_idx <= 1'b1;
                    end else begin
                        data_idx <= 1'b0;
                        fb_vld   <= 1'b1;
                        fb_d1    <= d1;
                        fb_val   <= rx_sh[6];
                    end
                end
            end
        end
    end

    // Map a completed CC onto the button it addresses (if any)
    always_comb begin
        fb_mask = '0;
        for (int i = 0; i < NUM_BTNS; i++)
            fb_mask[i] = fb_vld && (fb_d1 == CC_LO + 8'(i));
    end

    // Toggle state and LEDs: dequeue wins for tog, RX feedback wins for LED
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tog <= '0;
            led <= '0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (TOGGLE_MASK[i]) begin
                    if (deq_mask[i])
                        tog[i] <= ~tog[i];
                    else if (fb_mask[i])
                        tog[i] <= fb_val;
                end
                if (fb_mask[i])
                    led[i] <= fb_val;
                else if (TOGGLE_MASK[i] && deq_mask[i])
                    led[i] <= ~tog[i];
            end
        end
    end

    assign bus.midi_tx = tx_line;
    assign bus.tx_busy = tx_busy;
    assign bus.rx_err  = rx_err_q;
    assign bus.btn_led = led;
endmodule

// File: tb/tb_midi_cc_engine.sv
// Bench for midi_cc_engine: two instances (momentary/full-status and
// toggle-on-button-0/running-status) at a reduced bit time of 16 clocks.
module tb_midi_cc_engine;
    localparam int CLK_HZ = 500000;
    localparam int BAUD   = 31250;
    localparam int B      = CLK_HZ / BAUD;
    localparam int NB     = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    midi_cc_engine_if #(.NUM_BTNS(NB)) ifa ();
    midi_cc_engine_if #(.NUM_BTNS(NB)) ifb ();

    midi_cc_engine #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_BTNS(NB), .FIRST_CC(46), .CHANNEL(0),
        .TOGGLE_MASK(4'b0000), .RUNNING_STATUS(1'b0)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    midi_cc_engine #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_BTNS(NB), .FIRST_CC(46), .CHANNEL(0),
        .TOGGLE_MASK(4'b0001), .RUNNING_STATUS(1'b1)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int checks   = 0;
    int failures = 0;
    int rxerr_a  = 0;
    int rxerr_b  = 0;

    always @(posedge clk) begin
        if (ifa.rx_err === 1'b1) rxerr_a <= rxerr_a + 1;
        if (ifb.rx_err === 1'b1) rxerr_b <= rxerr_b + 1;
    end

    typedef struct {
        logic [7:0] data;
        bit         bad;
        logic [3:0] led;
    } rx_vec_t;

    rx_vec_t vecs [0:27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic press(input bit sel, input logic [3:0] m);
        if (sel) ifb.btn_rise = m; else ifa.btn_rise = m;
        @(negedge clk);
        if (sel) ifb.btn_rise = '0; else ifa.btn_rise = '0;
    endtask

    task automatic drive_rx(input bit sel, input logic v);
        if (sel) ifb.midi_rx = v; else ifa.midi_rx = v;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] d, input bit bad);
        logic [9:0] fr;
        fr = {~bad, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            drive_rx(sel, fr[k]);
            repeat (B) @(negedge clk);
        end
        drive_rx(sel, 1'b1);
        repeat (2 * B) @(negedge clk);
    endtask

    // Waits for a start bit, then checks every clock of the message
    task automatic check_msg(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int nbytes, input string name,
                             output int lat);
        logic [29:0] stream;
        int bad;
        bad    = 0;
        stream = {1'b1, b2, 1'b0, 1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
        lat    = 0;
        while ((sel ? ifb.midi_tx : ifa.midi_tx) !== 1'b0 && lat < 100 * B) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100 * B) begin
            checks++;
            failures++;
            $display("FAIL %s start: no start bit within %0d cycles", name, 100 * B);
            return;
        end
        for (int c = 0; c < nbytes * 10 * B; c++) begin
            if ((sel ? ifb.midi_tx : ifa.midi_tx) !== stream[c / B]) bad++;
            if ((sel ? ifb.tx_busy : ifa.tx_busy) !== 1'b1) bad++;
            @(negedge clk);
        end
        check({name, " bit errors"}, bad, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int busy_cycles;
        int e0;

        vecs[0]  = '{8'hB0, 1'b0, 4'b0000};
        vecs[1]  = '{8'h30, 1'b0, 4'b0000};
        vecs[2]  = '{8'h40, 1'b0, 4'b0100};
        vecs[3]  = '{8'hF8, 1'b0, 4'b0100};
        vecs[4]  = '{8'h31, 1'b0, 4'b0100};
        vecs[5]  = '{8'h10, 1'b0, 4'b0100};
        vecs[6]  = '{8'h31, 1'b0, 4'b0100};
        vecs[7]  = '{8'hFA, 1'b0, 4'b0100};
        vecs[8]  = '{8'h7F, 1'b0, 4'b1100};
        vecs[9]  = '{8'h30, 1'b0, 4'b1100};
        vecs[10] = '{8'h00, 1'b0, 4'b1000};
        vecs[11] = '{8'hB1, 1'b0, 4'b1000};
        vecs[12] = '{8'h2E, 1'b0, 4'b1000};
        vecs[13] = '{8'h7F, 1'b0, 4'b1000};
        vecs[14] = '{8'hB0, 1'b0, 4'b1000};
        vecs[15] = '{8'h2E, 1'b0, 4'b1000};
        vecs[16] = '{8'h7F, 1'b1, 4'b1000};
        vecs[17] = '{8'h7F, 1'b0, 4'b1001};
        vecs[18] = '{8'h35, 1'b0, 4'b1001};
        vecs[19] = '{8'h7F, 1'b0, 4'b1001};
        vecs[20] = '{8'h90, 1'b0, 4'b1001};
        vecs[21] = '{8'h2F, 1'b0, 4'b1001};
        vecs[22] = '{8'h7F, 1'b0, 4'b1001};
        vecs[23] = '{8'hB0, 1'b0, 4'b1001};
        vecs[24] = '{8'h2F, 1'b0, 4'b1001};
        vecs[25] = '{8'h40, 1'b0, 4'b1011};
        vecs[26] = '{8'h2F, 1'b0, 4'b1011};
        vecs[27] = '{8'h3F, 1'b0, 4'b1001};

        ifa.btn_rise = '0; ifa.midi_rx = 1'b1;
        ifb.btn_rise = '0; ifb.midi_rx = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset a midi_tx", ifa.midi_tx, 1);
        check("reset a tx_busy", ifa.tx_busy, 0);
        check("reset a rx_err", ifa.rx_err, 0);
        check("reset a btn_led", ifa.btn_led, 0);
        check("reset b midi_tx", ifb.midi_tx, 1);
        check("reset b btn_led", ifb.btn_led, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single press of button 1
        press(1'b0, 4'b0010);
        check_msg(1'b0, 8'hB0, 8'h2F, 8'h7F, 3, "t1 msg", lat);
        check("t1 latency", lat, 2);
        check("t1 busy after", ifa.tx_busy, 0);
        check("t1 line idle", ifa.midi_tx, 1);

        // Two buttons at once, repeat rise on a still-pending button during TX
        press(1'b0, 4'b1010);
        fork
            check_msg(1'b0, 8'hB0, 8'h2F, 8'h7F, 3, "t2 first", lat);
            begin
                repeat (5 * B) @(negedge clk);
                ifa.btn_rise = 4'b1000;
                @(negedge clk);
                ifa.btn_rise = '0;
            end
        join
        check("t2 first latency", lat, 2);
        check_msg(1'b0, 8'hB0, 8'h31, 8'h7F, 3, "t2 second", lat);
        check("t2 gap", lat, 0);
        check("t2 busy after", ifa.tx_busy, 0);
        busy_cycles = 0;
        repeat (40 * B) begin
            @(negedge clk);
            if (ifa.tx_busy !== 1'b0) busy_cycles++;
        end
        check("t2 no third msg", busy_cycles, 0);

        // Toggle button with running status
        press(1'b1, 4'b0001);
        check_msg(1'b1, 8'hB0, 8'h2E, 8'h7F, 3, "t3 press1", lat);
        check("t3 led after press1", ifb.btn_led, 4'b0001);
        press(1'b1, 4'b0001);
        check_msg(1'b1, 8'h2E, 8'h00, 8'h00, 2, "t3 press2", lat);
        check("t3 led after press2", ifb.btn_led, 4'b0000);
        check("t3 busy after short msg", ifb.tx_busy, 0);
        press(1'b1, 4'b0010);
        check_msg(1'b1, 8'h2F, 8'h7F, 8'h00, 2, "t3 momentary rs", lat);
        check("t3 led momentary", ifb.btn_led, 4'b0000);

        // Host feedback sets toggle state; next press flips from it
        send_byte(1'b1, 8'hB0, 1'b0);
        send_byte(1'b1, 8'h2E, 1'b0);
        send_byte(1'b1, 8'h7F, 1'b0);
        check("t3 led from host", ifb.btn_led, 4'b0001);
        press(1'b1, 4'b0001);
        check_msg(1'b1, 8'h2E, 8'h00, 8'h00, 2, "t3 press after host", lat);
        check("t3 led after host press", ifb.btn_led, 4'b0000);

        // RX parser vectors
        for (int i = 0; i < 28; i++) begin
            e0 = rxerr_a;
            send_byte(1'b0, vecs[i].data, vecs[i].bad);
            check($sformatf("rx vec %0d led", i), ifa.btn_led, vecs[i].led);
            check($sformatf("rx vec %0d err pulses", i), rxerr_a - e0, int'(vecs[i].bad));
        end

        // Reset mid-transmission, then a short glitch on the RX line
        press(1'b0, 4'b0101);
        repeat (5 * B) @(negedge clk);
        check("t5 busy before reset", ifa.tx_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t5 tx high on reset", ifa.midi_tx, 1);
        check("t5 busy low on reset", ifa.tx_busy, 0);
        check("t5 led cleared", ifa.btn_led, 0);
        @(negedge clk);
        rst = 1'b1;
        e0 = rxerr_a;
        ifa.midi_rx = 1'b0;
        repeat (B / 4) @(negedge clk);
        ifa.midi_rx = 1'b1;
        busy_cycles = 0;
        repeat (40 * B) begin
            @(negedge clk);
            if (ifa.tx_busy !== 1'b0) busy_cycles++;
        end
        check("t5 pending cleared", busy_cycles, 0);
        check("t5 glitch no rx_err", rxerr_a - e0, 0);
        send_byte(1'b0, 8'hB0, 1'b0);
        send_byte(1'b0, 8'h30, 1'b0);
        send_byte(1'b0, 8'h7F, 1'b0);
        check("t5 rx after glitch", ifa.btn_led, 4'b0100);
        check("t5 no rx_err total", rxerr_a - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
